// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared types and button indices for the alarm-clock button front-end.
// Revision : 1.0
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TSET = 2'd1,
        ASET = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ADV_NONE = 2'd0,
        ADV_MIN  = 2'd1,
        ADV_HRS  = 2'd2,
        ADV_DYS  = 2'd3
    } adv_t;

    localparam int N_BTN   = 6;

    // Bit positions of each button inside the packed button vectors
    localparam int BTN_TS  = 0;
    localparam int BTN_AS  = 1;
    localparam int BTN_MIN = 2;
    localparam int BTN_HRS = 3;
    localparam int BTN_DYS = 4;
    localparam int BTN_AON = 5;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser plus stable-count debouncer with rise pulse.
// Revision : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int            CW         = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The level flips on the cycle the count would reach DB_CYC
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_cnt  <= '0;
                r_db   <= r_s2;
                r_rise <= r_s2;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign db   = r_db;
    assign rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_ctrl
// Purpose  : Button front-end: debounce, mode FSM, advance strobes, alarm toggle.
// Revision : 1.0
// ============================================================================
module btn_ctrl
    import btn_pkg::*;
#(
    parameter int DB_CYC   = 16,
    parameter int HOLD_CYC = 8,
    parameter int RPT_CYC  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ts_raw,
    input  logic as_raw,
    input  logic min_raw,
    input  logic hrs_raw,
    input  logic dys_raw,
    input  logic aon_raw,
    output logic Timeset,
    output logic Alarmset,
    output logic Minadv,
    output logic Hrsadv,
    output logic Dysadv,
    output logic Alarmon
);

    localparam int            HOLD_MAX = max2(HOLD_CYC, RPT_CYC);
    localparam int            HW       = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] C_HOLD   = HW'(HOLD_CYC);
    localparam logic [HW-1:0] C_RPT    = HW'(RPT_CYC);
    localparam logic [HW-1:0] C_ONE    = HW'(1);

    logic [N_BTN-1:0] w_raw;
    logic [N_BTN-1:0] w_db;
    logic [N_BTN-1:0] w_rise;

    assign w_raw = {aon_raw, dys_raw, hrs_raw, min_raw, as_raw, ts_raw};

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            btn_debounce #(
                .DB_CYC (DB_CYC)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .raw  (w_raw[i]),
                .db   (w_db[i]),
                .rise (w_rise[i])
            );
        end
    endgenerate

    // Mode buttons are level-driven and the alarm toggle is edge-driven
    logic w_unused;
    assign w_unused = ^{w_rise[BTN_TS], w_rise[BTN_AS], w_db[BTN_AON]};

    mode_t r_mode;
    mode_t w_mode_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode <= IDLE;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            IDLE: begin
                if (w_db[BTN_TS] && !w_db[BTN_AS]) begin
                    w_mode_nxt = TSET;
                end else if (w_db[BTN_AS] && !w_db[BTN_TS]) begin
                    w_mode_nxt = ASET;
                end
            end
            TSET: if (!w_db[BTN_TS]) w_mode_nxt = IDLE;
            ASET: if (!w_db[BTN_AS]) w_mode_nxt = IDLE;
            default: w_mode_nxt = IDLE;
        endcase
    end

    adv_t          r_owner;
    adv_t          w_owner_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_rpt;
    logic          w_rpt_nxt;
    logic          w_fire;
    logic          w_owner_held;
    logic          w_in_mode;

    // Exit cycle counts as out-of-mode so no strobe leaks on the way to IDLE
    assign w_in_mode = (r_mode != IDLE) && (w_mode_nxt != IDLE);

    always_comb begin
        w_owner_held = 1'b0;
        case (r_owner)
            ADV_MIN: w_owner_held = w_db[BTN_MIN];
            ADV_HRS: w_owner_held = w_db[BTN_HRS];
            ADV_DYS: w_owner_held = w_db[BTN_DYS];
            default: w_owner_held = 1'b0;
        endcase
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_rpt_nxt   = r_rpt;
        w_fire      = 1'b0;
        if (!w_in_mode) begin
            w_owner_nxt = ADV_NONE;
            w_hold_nxt  = '0;
            w_rpt_nxt   = 1'b0;
        end else if (r_owner == ADV_NONE) begin
            w_hold_nxt = C_ONE;
            w_rpt_nxt  = 1'b0;
            w_fire     = 1'b1;
            if (w_rise[BTN_MIN]) begin
                w_owner_nxt = ADV_MIN;
            end else if (w_rise[BTN_HRS]) begin
                w_owner_nxt = ADV_HRS;
            end else if (w_rise[BTN_DYS] && (r_mode == TSET)) begin
                w_owner_nxt = ADV_DYS;
            end else begin
                w_hold_nxt = '0;
                w_fire     = 1'b0;
            end
        end else if (!w_owner_held) begin
            w_owner_nxt = ADV_NONE;
            w_hold_nxt  = '0;
            w_rpt_nxt   = 1'b0;
        end else if ((!r_rpt && (r_hold == C_HOLD)) || (r_rpt && (r_hold == C_RPT))) begin
            w_fire     = 1'b1;
            w_hold_nxt = C_ONE;
            w_rpt_nxt  = 1'b1;
        end else begin
            w_hold_nxt = r_hold + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner  <= ADV_NONE;
            r_hold   <= '0;
            r_rpt    <= 1'b0;
            Timeset  <= 1'b0;
            Alarmset <= 1'b0;
            Minadv   <= 1'b0;
            Hrsadv   <= 1'b0;
            Dysadv   <= 1'b0;
            Alarmon  <= 1'b0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_hold   <= w_hold_nxt;
            r_rpt    <= w_rpt_nxt;
            Timeset  <= (w_mode_nxt == TSET);
            Alarmset <= (w_mode_nxt == ASET);
            Minadv   <= w_fire && (w_owner_nxt == ADV_MIN);
            Hrsadv   <= w_fire && (w_owner_nxt == ADV_HRS);
            Dysadv   <= w_fire && (w_owner_nxt == ADV_DYS);
            Alarmon  <= Alarmon ^ w_rise[BTN_AON];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_ctrl
// Purpose  : Directed self-checking bench for btn_ctrl (DB=4, HOLD=8, RPT=2).
// Revision : 1.0
// ============================================================================
module tb_btn_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ts_raw = 1'b0, as_raw = 1'b0, min_raw = 1'b0;
    logic hrs_raw = 1'b0, dys_raw = 1'b0, aon_raw = 1'b0;
    logic Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_ctrl #(
        .DB_CYC   (4),
        .HOLD_CYC (8),
        .RPT_CYC  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ts_raw   (ts_raw),
        .as_raw   (as_raw),
        .min_raw  (min_raw),
        .hrs_raw  (hrs_raw),
        .dys_raw  (dys_raw),
        .aon_raw  (aon_raw),
        .Timeset  (Timeset),
        .Alarmset (Alarmset),
        .Minadv   (Minadv),
        .Hrsadv   (Hrsadv),
        .Dysadv   (Dysadv),
        .Alarmon  (Alarmon)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_raw();
        ts_raw = 0; as_raw = 0; min_raw = 0; hrs_raw = 0; dys_raw = 0; aon_raw = 0;
    endtask

    task automatic do_reset();
        clear_raw();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        ts_raw = 1; as_raw = 1; min_raw = 1; hrs_raw = 1; dys_raw = 1; aon_raw = 1;
        rst = 1'b0;
        step(3);
        n_run++;
        if ({Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon});
        end
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            n_run++;
            if (Timeset !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_timeset_low cyc %0d: got %b expected 0", k, Timeset);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        repeat (3) begin
            ts_raw = 1;
            for (int k = 0; k < 3; k++) begin
                step(1);
                n_run++;
                if (Timeset !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_high_phase: got %b expected 0", Timeset);
                end
            end
            ts_raw = 0;
            for (int k = 0; k < 3; k++) begin
                step(1);
                n_run++;
                if (Timeset !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_low_phase: got %b expected 0", Timeset);
                end
            end
        end
        ts_raw = 1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            n_run++;
            if (Timeset !== (k == 7)) begin
                n_fail++;
                $display("FAIL bounce_settle cyc %0d: got %b expected %b", k, Timeset, (k == 7));
            end
        end
    endtask

    task automatic test_repeat();
        int   n_min, n_other;
        logic exp;
        n_min = 0; n_other = 0;
        do_reset();
        ts_raw = 1;
        step(8);
        n_run++;
        if (Timeset !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_enter_tset: got %b expected 1", Timeset);
        end
        min_raw = 1;
        for (int k = 1; k <= 60; k++) begin
            step(1);
            exp = (k == 7) || (k >= 15 && k <= 45 && (k % 2) == 1);
            n_run++;
            if (Minadv !== exp) begin
                n_fail++;
                $display("FAIL repeat_minadv cyc %0d: got %b expected %b", k, Minadv, exp);
            end
            if (Minadv === 1'b1) n_min++;
            if (Hrsadv !== 1'b0 || Dysadv !== 1'b0) n_other++;
            if (k == 40) min_raw = 0;
        end
        n_run++;
        if (n_min != 17) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected 17", n_min);
        end
        n_run++;
        if (n_other != 0) begin
            n_fail++;
            $display("FAIL repeat_other_strobes: got %0d expected 0", n_other);
        end
        ts_raw = 0;
        step(10);
    endtask

    task automatic test_priority();
        int n_min, n_hrs, n_dys;
        do_reset();
        as_raw = 1;
        step(8);
        n_run++;
        if (Alarmset !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_enter_aset: got %b expected 1", Alarmset);
        end
        min_raw = 1; hrs_raw = 1;
        n_min = 0; n_hrs = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 7) begin
                n_run++;
                if (Minadv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prio_first_min: got %b expected 1", Minadv);
                end
            end
            if (Minadv === 1'b1) n_min++;
            if (Hrsadv === 1'b1) n_hrs++;
        end
        n_run++;
        if (n_min != 4 || n_hrs != 0) begin
            n_fail++;
            $display("FAIL prio_simultaneous: got min=%0d hrs=%0d expected min=4 hrs=0", n_min, n_hrs);
        end
        min_raw = 0;
        n_min = 0; n_hrs = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (Minadv === 1'b1) n_min++;
            if (Hrsadv === 1'b1) n_hrs++;
        end
        n_run++;
        if (n_min != 3 || n_hrs != 0) begin
            n_fail++;
            $display("FAIL prio_no_handover: got min=%0d hrs=%0d expected min=3 hrs=0", n_min, n_hrs);
        end
        hrs_raw = 0;
        step(10);
        hrs_raw = 1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            n_run++;
            if (Hrsadv !== (k == 7)) begin
                n_fail++;
                $display("FAIL prio_hrs_repress cyc %0d: got %b expected %b", k, Hrsadv, (k == 7));
            end
        end
        hrs_raw = 0;
        step(10);
        dys_raw = 1;
        n_dys = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (Dysadv === 1'b1) n_dys++;
        end
        n_run++;
        if (n_dys != 0) begin
            n_fail++;
            $display("FAIL prio_dys_in_aset: got %0d strobes expected 0", n_dys);
        end
        dys_raw = 0;
        as_raw = 0;
        step(10);
    endtask

    task automatic test_conflict();
        int n_min;
        do_reset();
        ts_raw = 1; as_raw = 1;
        step(10);
        n_run++;
        if (Timeset !== 1'b0 || Alarmset !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_idle: got ts=%b as=%b expected 0 0", Timeset, Alarmset);
        end
        min_raw = 1;
        n_min = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (Minadv === 1'b1) n_min++;
        end
        n_run++;
        if (n_min != 0) begin
            n_fail++;
            $display("FAIL conflict_no_strobe: got %0d expected 0", n_min);
        end
        min_raw = 0;
        step(10);
        as_raw = 0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            n_run++;
            if (Timeset !== (k == 7)) begin
                n_fail++;
                $display("FAIL conflict_to_tset cyc %0d: got %b expected %b", k, Timeset, (k == 7));
            end
        end
    endtask

    task automatic test_alarm_abort();
        int n_early, n_late, n_min;
        do_reset();
        aon_raw = 1;
        step(6);
        n_run++;
        if (Alarmon !== 1'b0) begin
            n_fail++;
            $display("FAIL aon_before_toggle: got %b expected 0", Alarmon);
        end
        step(1);
        n_run++;
        if (Alarmon !== 1'b1) begin
            n_fail++;
            $display("FAIL aon_first_toggle: got %b expected 1", Alarmon);
        end
        step(3);
        aon_raw = 0;
        step(10);
        n_run++;
        if (Alarmon !== 1'b1) begin
            n_fail++;
            $display("FAIL aon_after_release: got %b expected 1", Alarmon);
        end
        aon_raw = 1;
        step(7);
        n_run++;
        if (Alarmon !== 1'b0) begin
            n_fail++;
            $display("FAIL aon_second_toggle: got %b expected 0", Alarmon);
        end
        aon_raw = 0;
        step(10);
        aon_raw = 1;
        step(50);
        n_run++;
        if (Alarmon !== 1'b1) begin
            n_fail++;
            $display("FAIL aon_long_hold: got %b expected 1", Alarmon);
        end
        aon_raw = 0;
        step(10);

        ts_raw = 1;
        step(8);
        min_raw = 1;
        step(20);
        ts_raw = 0;
        n_early = 0; n_late = 0;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            if (Minadv === 1'b1) begin
                if (j <= 6) n_early++;
                else n_late++;
            end
            if (j == 6 || j == 7) begin
                n_run++;
                if (Timeset !== (j == 6)) begin
                    n_fail++;
                    $display("FAIL abort_timeset cyc %0d: got %b expected %b", j, Timeset, (j == 6));
                end
            end
        end
        n_run++;
        if (n_early != 3 || n_late != 0) begin
            n_fail++;
            $display("FAIL abort_exit_strobes: got early=%0d late=%0d expected 3 0", n_early, n_late);
        end

        ts_raw = 1;
        step(8);
        min_raw = 0;
        step(10);
        min_raw = 1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 15) begin
                n_run++;
                if (Minadv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_second_strobe: got %b expected 1", Minadv);
                end
            end
        end
        rst = 1'b0;
        step(1);
        n_run++;
        if ({Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_reset_outputs: got %b expected 000000",
                     {Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon});
        end
        step(2);
        rst = 1'b1;
        n_min = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (Minadv === 1'b1) n_min++;
        end
        n_run++;
        if (n_min != 0 || Alarmon !== 1'b0 || Timeset !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_after_reset: got strobes=%0d aon=%b ts=%b expected 0 0 1",
                     n_min, Alarmon, Timeset);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounce();
        test_repeat();
        test_priority();
        test_conflict();
        test_alarm_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
